// File: rtl/pulse_burst_gen.sv
// Burst generator driven by an external tick strobe: emits cmd_num pulses with
// programmable high/low phase lengths (in ticks), valid/ready command intake, done strobe.
module pulse_burst_gen #(
  parameter int CW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tck,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic [CW-1:0] cmd_num,
  input  logic [LW-1:0] cmd_hig,
  input  logic [LW-1:0] cmd_low,
  input  logic          abt,
  output logic          out,
  output logic          bsy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] TMR_ZERO = LW'(0);
  localparam logic [LW-1:0] TMR_ONE  = LW'(1);

  state_e        state_q, state_d;
  logic          out_q, out_d;
  logic          bsy_q, bsy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] tmr_q, tmr_d;
  logic [LW-1:0] hig_q, hig_d;
  logic [LW-1:0] low_q, low_d;
  logic          accept_s;

  assign cmd_rdy  = (state_q == ST_IDLE) & ~abt;
  assign accept_s = cmd_vld & cmd_rdy;

  assign out  = out_q;
  assign bsy  = bsy_q;
  assign done = done_q;
  assign cnt  = cnt_q;

  // Next-state and output decode; abort overrides any tick in the same cycle.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    hig_d   = hig_q;
    low_d   = low_q;
    if (abt && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      out_d   = 1'b0;
      cnt_d   = CNT_ZERO;
      tmr_d   = TMR_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            hig_d = (cmd_hig == TMR_ZERO) ? TMR_ONE : cmd_hig;
            low_d = (cmd_low == TMR_ZERO) ? TMR_ONE : cmd_low;
            cnt_d = cmd_num;
            if (cmd_num == CNT_ZERO) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_ARM;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (tck) begin
            state_d = ST_HIGH;
            out_d   = 1'b1;
            tmr_d   = hig_q;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_HIGH: begin
          if (!tck) begin
            state_d = ST_HIGH;
          end else if (tmr_q != TMR_ONE) begin
            tmr_d = tmr_q - TMR_ONE;
          end else if (cnt_q == CNT_ONE) begin
            out_d   = 1'b0;
            cnt_d   = CNT_ZERO;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            out_d   = 1'b0;
            cnt_d   = cnt_q - CNT_ONE;
            tmr_d   = low_q;
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (!tck) begin
            state_d = ST_LOW;
          end else if (tmr_q != TMR_ONE) begin
            tmr_d = tmr_q - TMR_ONE;
          end else begin
            out_d   = 1'b1;
            tmr_d   = hig_q;
            state_d = ST_HIGH;
          end
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
          cnt_d   = CNT_ZERO;
          tmr_d   = TMR_ZERO;
        end
      endcase
    end
    bsy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears the pulse output without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
      bsy_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
      tmr_q   <= TMR_ZERO;
      hig_q   <= TMR_ONE;
      low_q   <= TMR_ONE;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      bsy_q   <= bsy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      hig_q   <= hig_d;
      low_q   <= low_d;
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed self-checking bench for pulse_burst_gen; outputs sampled 1 ns after each rising edge.
module tb_pulse_burst_gen;

  logic        clk;
  logic        rst;
  logic        tck;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [15:0] cmd_num;
  logic [7:0]  cmd_hig;
  logic [7:0]  cmd_low;
  logic        abt;
  logic        out;
  logic        bsy;
  logic        done;
  logic [15:0] cnt;

  int n_chk;
  int n_fail;

  pulse_burst_gen #(.CW(16), .LW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .tck     (tck),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_num (cmd_num),
    .cmd_hig (cmd_hig),
    .cmd_low (cmd_low),
    .abt     (abt),
    .out     (out),
    .bsy     (bsy),
    .done    (done),
    .cnt     (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] num, input logic [7:0] hig, input logic [7:0] low);
    cmd_vld = 1'b1;
    cmd_num = num;
    cmd_hig = hig;
    cmd_low = low;
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tck = 1'b0; cmd_vld = 1'b0; abt = 1'b0;
    cmd_num = 16'd0; cmd_hig = 8'd0; cmd_low = 8'd0;
    #12;
    n_chk++;
    if ({out, bsy, done, cnt} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: out=%b bsy=%b done=%b cnt=%0d, expected all 0", out, bsy, done, cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_chk++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy: cmd_rdy=%b expected 1", cmd_rdy);
    end
  endtask

  task automatic test_basic();
    logic        exp_out;
    logic [15:0] exp_cnt;
    tck = 1'b0;
    issue(16'd3, 8'd2, 8'd1);
    for (int i = 0; i < 36; i++) begin
      tck = (i % 4 == 0);
      step();
      exp_out = (i < 8) || (i >= 12 && i < 20) || (i >= 24 && i < 32);
      exp_cnt = (i < 8) ? 16'd3 : (i < 20) ? 16'd2 : (i < 32) ? 16'd1 : 16'd0;
      n_chk++;
      if (out !== exp_out) begin
        n_fail++;
        $display("FAIL basic_out cyc %0d: got %b expected %b", i, out, exp_out);
      end
      n_chk++;
      if (cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL basic_cnt cyc %0d: got %0d expected %0d", i, cnt, exp_cnt);
      end
      n_chk++;
      if ((done !== (i == 32)) || (bsy !== (i < 32))) begin
        n_fail++;
        $display("FAIL basic_done_bsy cyc %0d: done=%b bsy=%b expected done=%b bsy=%b",
                 i, done, bsy, (i == 32), (i < 32));
      end
    end
    tck = 1'b0;
  endtask

  task automatic test_zero_count();
    n_chk++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_rdy_before: cmd_rdy=%b expected 1", cmd_rdy);
    end
    issue(16'd0, 8'd5, 8'd7);
    n_chk++;
    if ({done, bsy, out, cmd_rdy} !== 4'b1001) begin
      n_fail++;
      $display("FAIL zero_done: done=%b bsy=%b out=%b rdy=%b expected 1,0,0,1", done, bsy, out, cmd_rdy);
    end
    step();
    n_chk++;
    if ({done, bsy, out, cmd_rdy} !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_after: done=%b bsy=%b out=%b rdy=%b expected 0,0,0,1", done, bsy, out, cmd_rdy);
    end
  endtask

  task automatic test_min_phase();
    logic exp_out;
    tck = 1'b1;
    issue(16'd4, 8'd0, 8'd0);
    n_chk++;
    if ({out, bsy} !== 2'b01) begin
      n_fail++;
      $display("FAIL minph_accept_tick: out=%b bsy=%b expected out=0 bsy=1", out, bsy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      exp_out = (i < 7) && (i % 2 == 0);
      n_chk++;
      if ((out !== exp_out) || (done !== (i == 7))) begin
        n_fail++;
        $display("FAIL minph_pattern cyc %0d: out=%b done=%b expected out=%b done=%b",
                 i, out, done, exp_out, (i == 7));
      end
    end
    tck = 1'b0;
  endtask

  task automatic test_abort();
    abt = 1'b1;
    cmd_vld = 1'b1; cmd_num = 16'd2; cmd_hig = 8'd1; cmd_low = 8'd1;
    #1;
    n_chk++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle_rdy: cmd_rdy=%b expected 0", cmd_rdy);
    end
    step();
    cmd_vld = 1'b0;
    abt = 1'b0;
    n_chk++;
    if ({bsy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle_block: bsy=%b done=%b expected 0,0", bsy, done);
    end
    tck = 1'b0;
    issue(16'd5, 8'd3, 8'd3);
    tck = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_chk++;
    if ({out, bsy, cnt} !== {1'b0, 1'b1, 16'd3}) begin
      n_fail++;
      $display("FAIL abort_pre_low2: out=%b bsy=%b cnt=%0d expected 0,1,3", out, bsy, cnt);
    end
    abt = 1'b1;
    step();
    abt = 1'b0;
    n_chk++;
    if ({out, bsy, done, cnt} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL abort_clear: out=%b bsy=%b done=%b cnt=%0d expected 0,0,0,0", out, bsy, done, cnt);
    end
    tck = 1'b0;
    issue(16'd1, 8'd1, 8'd1);
    n_chk++;
    if ({bsy, done, cnt} !== {1'b1, 1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL abort_reaccept: bsy=%b done=%b cnt=%0d expected 1,0,1", bsy, done, cnt);
    end
    tck = 1'b1;
    step();
    step();
    n_chk++;
    if ({out, done, bsy} !== 3'b010) begin
      n_fail++;
      $display("FAIL abort_followup_done: out=%b done=%b bsy=%b expected 0,1,0", out, done, bsy);
    end
    tck = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    tck = 1'b0;
    issue(16'd1, 8'd2, 8'd1);
    tck = 1'b1;
    step();
    step();
    step();
    n_chk++;
    if ({done, cmd_rdy, out} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_done_cycle: done=%b rdy=%b out=%b expected 1,1,0", done, cmd_rdy, out);
    end
    issue(16'd2, 8'd1, 8'd1);
    n_chk++;
    if ({bsy, out, done, cnt} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL b2b_accept: bsy=%b out=%b done=%b cnt=%0d expected 1,0,0,2", bsy, out, done, cnt);
    end
    tck = 1'b0;
    step();
    n_chk++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_arm_wait: out=%b expected 0", out);
    end
    tck = 1'b1;
    step();
    n_chk++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_high: out=%b expected 1", out);
    end
    step();
    step();
    step();
    n_chk++;
    if ({out, done, cnt} !== {1'b0, 1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL b2b_second_done: out=%b done=%b cnt=%0d expected 0,1,0", out, done, cnt);
    end
    tck = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    tck = 1'b0;
    issue(16'd2, 8'd4, 8'd1);
    tck = 1'b1;
    step();
    n_chk++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre_high: out=%b expected 1", out);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({out, bsy, cnt} !== {1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL areset_immediate: out=%b bsy=%b cnt=%0d expected 0,0,0", out, bsy, cnt);
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({out, bsy, cmd_rdy, cnt} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
        n_fail++;
        $display("FAIL areset_after cyc %0d: out=%b bsy=%b rdy=%b cnt=%0d expected 0,0,1,0",
                 i, out, bsy, cmd_rdy, cnt);
      end
    end
    tck = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_zero_count();
    test_min_phase();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
